// File: rtl/serial_cmp_pkg.sv
// Shared types and digit/state helpers for the serial magnitude comparator.
// Digits are widened to XW bits by the caller so one function fits every DIGIT_W.
package serial_cmp_pkg;

   localparam int XW = 33;

   typedef enum logic [1:0] {
      CMP_EQ = 2'b00,
      CMP_LT = 2'b01,
      CMP_GT = 2'b10
   } cmp_state_t;

   function automatic cmp_state_t digit_cmp(
      input logic [XW-1:0] a,
      input logic [XW-1:0] b,
      input logic          signed_digit
   );
      logic lt;
      lt = signed_digit ? ($signed(a) < $signed(b)) : (a < b);
      if (a == b)
         return CMP_EQ;
      return lt ? CMP_LT : CMP_GT;
   endfunction

   function automatic cmp_state_t state_next(
      input cmp_state_t state,
      input cmp_state_t digit_res,
      input logic       msb_first
   );
      if (msb_first)
         return (state == CMP_EQ) ? digit_res : state;
      return (digit_res != CMP_EQ) ? digit_res : state;
   endfunction

endpackage

// File: rtl/serial_cmp_lane.sv
// One comparator lane: state register plus next-state logic.
// state_nxt is exported so the top can capture the final beat's update.
module serial_cmp_lane
   import serial_cmp_pkg::*;
#(
   parameter int DIGIT_W = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               first,
   input  logic               msb_first,
   input  logic               signed_digit,
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   output cmp_state_t         state_nxt
);

   cmp_state_t        state_q;
   cmp_state_t        base;
   logic [XW-1:0]     a_x;
   logic [XW-1:0]     b_x;

   // sign-extend only the digit that carries the operand sign
   assign a_x = {{(XW-DIGIT_W){signed_digit & a[DIGIT_W-1]}}, a};
   assign b_x = {{(XW-DIGIT_W){signed_digit & b[DIGIT_W-1]}}, b};

   assign base = first ? CMP_EQ : state_q;

   assign state_nxt = en
      ? state_next(base, digit_cmp(a_x, b_x, signed_digit), msb_first)
      : state_q;

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= CMP_EQ;
      else
         state_q <= state_nxt;
   end

endmodule

// File: rtl/serial_comparator_multichannel.sv
// Multi-lane framed serial magnitude comparator (valid/last, per-word bit order).
// Define SERIAL_CMP_SIGNED_EN to add the is_signed port (two's complement top digit).
module serial_comparator_multichannel
   import serial_cmp_pkg::*;
#(
   parameter int DIGIT_W   = 1,
   parameter int N_CH      = 1,
   parameter int MAX_BEATS = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic                    in_last,
   input  logic                    msb_first,
`ifdef SERIAL_CMP_SIGNED_EN
   input  logic                    is_signed,
`endif
   input  logic [N_CH*DIGIT_W-1:0] a,
   input  logic [N_CH*DIGIT_W-1:0] b,
   output logic                    busy,
   output logic                    res_valid,
   output logic [N_CH-1:0]         res_lt,
   output logic [N_CH-1:0]         res_eq,
   output logic [N_CH-1:0]         res_gt,
   output logic                    res_len_err
);

   localparam int CW = $clog2(MAX_BEATS + 2);

   logic          first;
   logic          msb_q;
   logic          msb_eff;
   logic          sgn_eff;
   logic          sdig;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_nxt;
   logic [N_CH-1:0] lt_v;
   logic [N_CH-1:0] eq_v;
   logic [N_CH-1:0] gt_v;
   cmp_state_t    st_nxt [N_CH];

   assign first   = in_valid & ~busy;
   assign msb_eff = first ? msb_first : msb_q;

`ifdef SERIAL_CMP_SIGNED_EN
   logic sgn_q;
   assign sgn_eff = first ? is_signed : sgn_q;
   always_ff @(posedge clk) begin
      if (rst)
         sgn_q <= 1'b0;
      else if (first)
         sgn_q <= is_signed;
   end
`else
   assign sgn_eff = 1'b0;
`endif

   // top digit: first beat for MSB-first, last beat for LSB-first
   assign sdig = sgn_eff & (msb_eff ? first : in_last);

   always_comb begin
      cnt_nxt = cnt_q;
      if (first)
         cnt_nxt = CW'(1);
      else if (cnt_q != CW'(MAX_BEATS + 1))
         cnt_nxt = cnt_q + CW'(1);
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_lane
      serial_cmp_lane #(
         .DIGIT_W (DIGIT_W)
      ) u_lane (
         .clk          (clk),
         .rst          (rst),
         .en           (in_valid),
         .first        (first),
         .msb_first    (msb_eff),
         .signed_digit (sdig),
         .a            (a[i*DIGIT_W +: DIGIT_W]),
         .b            (b[i*DIGIT_W +: DIGIT_W]),
         .state_nxt    (st_nxt[i])
      );
      assign lt_v[i] = (st_nxt[i] == CMP_LT);
      assign eq_v[i] = (st_nxt[i] == CMP_EQ);
      assign gt_v[i] = (st_nxt[i] == CMP_GT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy        <= 1'b0;
         res_valid   <= 1'b0;
         res_lt      <= '0;
         res_eq      <= '1;
         res_gt      <= '0;
         res_len_err <= 1'b0;
         cnt_q       <= '0;
         msb_q       <= 1'b0;
      end else begin
         res_valid <= in_valid & in_last;
         if (first)
            msb_q <= msb_first;
         if (in_valid) begin
            busy  <= ~in_last;
            cnt_q <= cnt_nxt;
         end
         if (in_valid && in_last) begin
            res_lt      <= lt_v;
            res_eq      <= eq_v;
            res_gt      <= gt_v;
            res_len_err <= (cnt_nxt > CW'(MAX_BEATS));
         end
      end
   end

endmodule

// File: tb/tb_serial_comparator_multichannel.sv
// Directed bench for serial_comparator_multichannel (DIGIT_W=4, N_CH=2, MAX_BEATS=4).
// Signed-digit scenario runs only when SERIAL_CMP_SIGNED_EN is defined.
module tb_serial_comparator_multichannel;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       msb_first = 1'b1;
`ifdef SERIAL_CMP_SIGNED_EN
   logic       is_signed = 1'b0;
`endif
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       busy;
   logic       res_valid;
   logic [1:0] res_lt;
   logic [1:0] res_eq;
   logic [1:0] res_gt;
   logic       res_len_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   serial_comparator_multichannel #(
      .DIGIT_W   (4),
      .N_CH      (2),
      .MAX_BEATS (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .msb_first   (msb_first),
`ifdef SERIAL_CMP_SIGNED_EN
      .is_signed   (is_signed),
`endif
      .a           (a),
      .b           (b),
      .busy        (busy),
      .res_valid   (res_valid),
      .res_lt      (res_lt),
      .res_eq      (res_eq),
      .res_gt      (res_gt),
      .res_len_err (res_len_err)
   );

   task automatic beat(input logic [7:0] av, input logic [7:0] bv,
                       input logic last, input logic msb);
      in_valid  = 1'b1;
      in_last   = last;
      msb_first = msb;
      a         = av;
      b         = bv;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);
      checks++;
      if ({busy, res_valid, res_lt, res_eq, res_gt, res_len_err} !== 9'b0_0_00_11_00_0) begin
         errors++;
         $display("FAIL reset_state: busy=%b vld=%b lt=%b eq=%b gt=%b le=%b want 0 0 00 11 00 0",
                  busy, res_valid, res_lt, res_eq, res_gt, res_len_err);
      end
   endtask

   task automatic test_msb_first;
      beat({4'h1, 4'h3}, {4'h2, 4'h3}, 1'b0, 1'b1);
      checks++;
      if (busy !== 1'b1 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL msb_busy: busy=%b vld=%b want 1 0", busy, res_valid);
      end
      beat({4'hF, 4'hA}, {4'h0, 4'h5}, 1'b1, 1'b1);
      checks++;
      if ({res_valid, busy, res_lt, res_eq, res_gt} !== 8'b1_0_10_00_01) begin
         errors++;
         $display("FAIL msb_result: vld=%b busy=%b lt=%b eq=%b gt=%b want 1 0 10 00 01",
                  res_valid, busy, res_lt, res_eq, res_gt);
      end
      idle(1);
      checks++;
      if (res_valid !== 1'b0 || res_gt !== 2'b01 || res_lt !== 2'b10) begin
         errors++;
         $display("FAIL msb_pulse_hold: vld=%b gt=%b lt=%b want 0 01 10", res_valid, res_gt, res_lt);
      end
   endtask

   task automatic test_lsb_first;
      beat({4'h0, 4'h3}, {4'h1, 4'h5}, 1'b0, 1'b0);
      beat({4'h2, 4'h5}, {4'h2, 4'h3}, 1'b1, 1'b0);
      checks++;
      if ({res_valid, res_lt, res_eq, res_gt} !== 7'b1_10_00_01) begin
         errors++;
         $display("FAIL lsb_result: vld=%b lt=%b eq=%b gt=%b want 1 10 00 01",
                  res_valid, res_lt, res_eq, res_gt);
      end
      idle(1);
   endtask

   task automatic test_gaps_equal;
      int pulses;
      pulses = 0;
      beat({4'h1, 4'h1}, {4'h1, 4'h1}, 1'b0, 1'b1);
      repeat (2) begin
         idle(1);
         if (res_valid === 1'b1) pulses++;
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL gap_busy: busy=%b want 1", busy);
      end
      beat({4'h2, 4'h2}, {4'h2, 4'h2}, 1'b1, 1'b0);
      if (res_valid === 1'b1) pulses++;
      checks++;
      if (res_eq !== 2'b11 || res_lt !== 2'b00 || res_gt !== 2'b00) begin
         errors++;
         $display("FAIL gap_eq: lt=%b eq=%b gt=%b want 00 11 00", res_lt, res_eq, res_gt);
      end
      repeat (3) begin
         idle(1);
         if (res_valid === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL gap_pulses: got %0d want 1", pulses);
      end
   endtask

   task automatic test_back_to_back;
      beat({4'h7, 4'h7}, {4'h2, 4'h2}, 1'b1, 1'b1);
      checks++;
      if (res_valid !== 1'b1 || res_gt !== 2'b11 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first: vld=%b gt=%b busy=%b want 1 11 0", res_valid, res_gt, busy);
      end
      beat({4'h2, 4'h2}, {4'h7, 4'h7}, 1'b1, 1'b1);
      checks++;
      if (res_valid !== 1'b1 || res_lt !== 2'b11 || res_gt !== 2'b00) begin
         errors++;
         $display("FAIL b2b_second: vld=%b lt=%b gt=%b want 1 11 00", res_valid, res_lt, res_gt);
      end
      idle(1);
   endtask

   task automatic test_reset_mid_word;
      beat({4'h1, 4'h1}, {4'h2, 4'h2}, 1'b0, 1'b1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      checks++;
      if ({busy, res_valid, res_lt, res_eq, res_gt, res_len_err} !== 9'b0_0_00_11_00_0) begin
         errors++;
         $display("FAIL midrst_state: busy=%b vld=%b lt=%b eq=%b gt=%b le=%b want 0 0 00 11 00 0",
                  busy, res_valid, res_lt, res_eq, res_gt, res_len_err);
      end
      beat({4'h5, 4'h5}, {4'h5, 4'h5}, 1'b1, 1'b1);
      checks++;
      if (res_valid !== 1'b1 || res_eq !== 2'b11 || res_lt !== 2'b00) begin
         errors++;
         $display("FAIL midrst_next: vld=%b eq=%b lt=%b want 1 11 00", res_valid, res_eq, res_lt);
      end
      idle(1);
   endtask

   task automatic test_length;
      for (int i = 0; i < 4; i++)
         beat(8'h33, 8'h33, (i == 3), 1'b1);
      checks++;
      if (res_valid !== 1'b1 || res_len_err !== 1'b0 || res_eq !== 2'b11) begin
         errors++;
         $display("FAIL len4: vld=%b le=%b eq=%b want 1 0 11", res_valid, res_len_err, res_eq);
      end
      idle(1);
      for (int i = 0; i < 5; i++)
         beat(8'h33, 8'h33, (i == 4), 1'b1);
      checks++;
      if (res_valid !== 1'b1 || res_len_err !== 1'b1 || res_eq !== 2'b11) begin
         errors++;
         $display("FAIL len5: vld=%b le=%b eq=%b want 1 1 11", res_valid, res_len_err, res_eq);
      end
      idle(1);
      beat(8'h31, 8'h13, 1'b1, 1'b1);
      checks++;
      if (res_len_err !== 1'b0 || res_gt !== 2'b10 || res_lt !== 2'b01) begin
         errors++;
         $display("FAIL len_clear: le=%b gt=%b lt=%b want 0 10 01", res_len_err, res_gt, res_lt);
      end
      idle(1);
   endtask

`ifdef SERIAL_CMP_SIGNED_EN
   task automatic test_signed;
      is_signed = 1'b1;
      beat(8'hFF, 8'h11, 1'b1, 1'b1);
      checks++;
      if (res_lt !== 2'b11 || res_gt !== 2'b00) begin
         errors++;
         $display("FAIL signed_on: lt=%b gt=%b want 11 00", res_lt, res_gt);
      end
      is_signed = 1'b0;
      beat(8'hFF, 8'h11, 1'b1, 1'b1);
      checks++;
      if (res_gt !== 2'b11 || res_lt !== 2'b00) begin
         errors++;
         $display("FAIL signed_off: lt=%b gt=%b want 00 11", res_lt, res_gt);
      end
      idle(1);
   endtask
`endif

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_gaps_equal();
      test_back_to_back();
      test_reset_mid_word();
      test_length();
`ifdef SERIAL_CMP_SIGNED_EN
      test_signed();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
